// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous-read memory port between the CPU datapath (LOAD/STOR)
// and the video scan-out reader. Each access takes three cycles: grant in IDLE,
// present the address (X_ADDR), capture the read data (X_DATA), then a one-cycle
// done pulse with the arbiter already back in IDLE. Round-robin on contention.
//
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   cpu_req/we/addr/wdata      CPU request; we/addr/wdata are sampled at grant
//   cpu_rdata, cpu_done        CPU read data (held) and completion pulse
//   vid_req/addr               video read request; addr is sampled at grant
//   vid_rdata, vid_done        video read data (held) and completion pulse
//   busy                       high whenever the FSM is outside IDLE
//   mem_addr/wdata/we/rdata    memory port; read data arrives one cycle after address

module mem_port_arbiter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [WIDTH-1:0]     cpu_wdata,
    output logic [WIDTH-1:0]     cpu_rdata,
    output logic                 cpu_done,
    input  logic                 vid_req,
    input  logic [ADDR_BITS-1:0] vid_addr,
    output logic [WIDTH-1:0]     vid_rdata,
    output logic                 vid_done,
    output logic                 busy,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 mem_we,
    input  logic [WIDTH-1:0]     mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StCpuAddr,
        StCpuData,
        StVidAddr,
        StVidData
    } state_e;

    localparam logic GrantCpu = 1'b0;
    localparam logic GrantVid = 1'b1;

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0]     cpu_rdata_q, cpu_rdata_d;
    logic [WIDTH-1:0]     vid_rdata_q, vid_rdata_d;
    logic                 cpu_done_q, cpu_done_d;
    logic                 vid_done_q, vid_done_d;

    // A request still high during its own done cycle is the tail of the access
    // just finished, not a new one.
    logic cpu_elig, vid_elig;
    assign cpu_elig = cpu_req & ~cpu_done_q;
    assign vid_elig = vid_req & ~vid_done_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= GrantCpu;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            vid_rdata_q  <= '0;
            cpu_done_q   <= 1'b0;
            vid_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vid_rdata_q  <= vid_rdata_d;
            cpu_done_q   <= cpu_done_d;
            vid_done_q   <= vid_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        vid_rdata_d  = vid_rdata_q;
        cpu_done_d   = 1'b0;
        vid_done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                // CPU wins if it is alone, or if both want the port and video went last.
                if (cpu_elig && (!vid_elig || last_grant_q == GrantVid)) begin
                    state_d      = StCpuAddr;
                    last_grant_d = GrantCpu;
                    we_d         = cpu_we;
                    mem_addr_d   = cpu_addr;
                    mem_wdata_d  = cpu_wdata;
                end else if (vid_elig) begin
                    state_d      = StVidAddr;
                    last_grant_d = GrantVid;
                    mem_addr_d   = vid_addr;
                end
            end
            StCpuAddr: state_d = StCpuData;
            StCpuData: begin
                if (!we_q) begin
                    cpu_rdata_d = mem_rdata;
                end
                cpu_done_d = 1'b1;
                state_d    = StIdle;
            end
            StVidAddr: state_d = StVidData;
            StVidData: begin
                vid_rdata_d = mem_rdata;
                vid_done_d  = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy   = (state_q != StIdle);
        mem_we = (state_q == StCpuAddr) && we_q;
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_rdata = vid_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign vid_done  = vid_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of per-cycle vectors (inputs plus
// the outputs expected after the next rising edge), followed by hand-written
// sequences for reset during an access and bounded done-latency checks.

module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_done;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic [15:0] vid_rdata;
    logic        vid_done;
    logic        busy;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    int n_vec;
    int n_err;

    mem_port_arbiter #(
        .WIDTH    (16),
        .ADDR_BITS(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_done (cpu_done),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_rdata(vid_rdata),
        .vid_done (vid_done),
        .busy     (busy),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory with a side door for preloading contents.
    logic [15:0] mem [0:65535];
    logic        pre_en;
    logic [15:0] pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct packed {
        logic        rst_n;
        logic        creq;
        logic        cwe;
        logic [15:0] caddr;
        logic [15:0] cwdata;
        logic        vreq;
        logic [15:0] vaddr;
        logic        e_cdone;
        logic [15:0] e_crdata;
        logic        e_vdone;
        logic [15:0] e_vrdata;
        logic        e_busy;
        logic        e_we;
        logic [15:0] e_maddr;
        logic [15:0] e_mwdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_n, logic creq, logic cwe, logic [15:0] caddr,
                                logic [15:0] cwdata, logic vreq, logic [15:0] vaddr,
                                logic e_cdone, logic [15:0] e_crdata, logic e_vdone,
                                logic [15:0] e_vrdata, logic e_busy, logic e_we,
                                logic [15:0] e_maddr, logic [15:0] e_mwdata);
        vec_t v;
        v.rst_n = rst_n;     v.creq = creq;         v.cwe = cwe;
        v.caddr = caddr;     v.cwdata = cwdata;     v.vreq = vreq;
        v.vaddr = vaddr;     v.e_cdone = e_cdone;   v.e_crdata = e_crdata;
        v.e_vdone = e_vdone; v.e_vrdata = e_vrdata; v.e_busy = e_busy;
        v.e_we = e_we;       v.e_maddr = e_maddr;   v.e_mwdata = e_mwdata;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(logic [15:0] a, logic [15:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_en   = 1'b0;
    endtask

    // Waits up to a budget of cycles for cpu_done; reports latency and mem_we cycles seen.
    task automatic wait_cpu_done(output int lat, output int we_cnt, output logic seen);
        lat    = 0;
        we_cnt = 0;
        seen   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            lat++;
            if (mem_we) we_cnt++;
            if (cpu_done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   lat;
        int   we_cnt;
        logic seen;
        logic any_done;

        n_vec = 0;
        n_err = 0;
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;

        tick();
        preload(16'h0010, 16'hBEEF);
        tick();

        // Reset released, idle for ten cycles.
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1,0,0,16'h0,16'h0,0,16'h0, 0,16'h0,0,16'h0,0,0,16'h0,16'h0));
        // CPU read of 0x0010; req held through done cycle, then dropped.
        vecs.push_back(mk(1,1,0,16'h0010,16'h0,0,16'h0, 0,16'h0000,0,16'h0,1,0,16'h0010,16'h0));
        vecs.push_back(mk(1,1,0,16'h0010,16'h0,0,16'h0, 0,16'h0000,0,16'h0,1,0,16'h0010,16'h0));
        vecs.push_back(mk(1,1,0,16'h0010,16'h0,0,16'h0, 1,16'hBEEF,0,16'h0,0,0,16'h0010,16'h0));
        vecs.push_back(mk(1,1,0,16'h0010,16'h0,0,16'h0, 0,16'hBEEF,0,16'h0,0,0,16'h0010,16'h0));
        vecs.push_back(mk(1,0,0,16'h0010,16'h0,0,16'h0, 0,16'hBEEF,0,16'h0,0,0,16'h0010,16'h0));
        // CPU write 0x1234 to 0x0020; address/data changed after grant must be ignored.
        vecs.push_back(mk(1,1,1,16'h0020,16'h1234,0,16'h0, 0,16'hBEEF,0,16'h0,1,1,16'h0020,16'h1234));
        vecs.push_back(mk(1,1,1,16'h0099,16'hFFFF,0,16'h0, 0,16'hBEEF,0,16'h0,1,0,16'h0020,16'h1234));
        vecs.push_back(mk(1,1,1,16'h0099,16'hFFFF,0,16'h0, 1,16'hBEEF,0,16'h0,0,0,16'h0020,16'h1234));
        vecs.push_back(mk(1,0,0,16'h0000,16'h0000,0,16'h0, 0,16'hBEEF,0,16'h0,0,0,16'h0020,16'h1234));
        // Read back 0x0020.
        vecs.push_back(mk(1,1,0,16'h0020,16'h0,0,16'h0, 0,16'hBEEF,0,16'h0,1,0,16'h0020,16'h0));
        vecs.push_back(mk(1,1,0,16'h0020,16'h0,0,16'h0, 0,16'hBEEF,0,16'h0,1,0,16'h0020,16'h0));
        vecs.push_back(mk(1,1,0,16'h0020,16'h0,0,16'h0, 1,16'h1234,0,16'h0,0,0,16'h0020,16'h0));
        vecs.push_back(mk(1,0,0,16'h0020,16'h0,0,16'h0, 0,16'h1234,0,16'h0,0,0,16'h0020,16'h0));
        // Reset clears the held read data and the latched port values.
        vecs.push_back(mk(0,0,0,16'h0,16'h0,0,16'h0, 0,16'h0,0,16'h0,0,0,16'h0,16'h0));
        // Simultaneous requests: video first, then strict alternation.
        vecs.push_back(mk(1,1,0,16'h0010,16'h0,1,16'h0020, 0,16'h0,0,16'h0,1,0,16'h0020,16'h0));
        vecs.push_back(mk(1,1,0,16'h0010,16'h0,1,16'h0020, 0,16'h0,0,16'h0,1,0,16'h0020,16'h0));
        vecs.push_back(mk(1,1,0,16'h0010,16'h0,1,16'h0020, 0,16'h0,1,16'h1234,0,0,16'h0020,16'h0));
        vecs.push_back(mk(1,1,0,16'h0010,16'h0,1,16'h0010, 0,16'h0,0,16'h1234,1,0,16'h0010,16'h0));
        vecs.push_back(mk(1,1,0,16'h0010,16'h0,1,16'h0010, 0,16'h0,0,16'h1234,1,0,16'h0010,16'h0));
        vecs.push_back(mk(1,1,0,16'h0010,16'h0,1,16'h0010, 1,16'hBEEF,0,16'h1234,0,0,16'h0010,16'h0));
        vecs.push_back(mk(1,1,0,16'h0010,16'h0,1,16'h0010, 0,16'hBEEF,0,16'h1234,1,0,16'h0010,16'h0));
        vecs.push_back(mk(1,1,0,16'h0010,16'h0,1,16'h0010, 0,16'hBEEF,0,16'h1234,1,0,16'h0010,16'h0));
        vecs.push_back(mk(1,1,0,16'h0010,16'h0,1,16'h0010, 0,16'hBEEF,1,16'hBEEF,0,0,16'h0010,16'h0));
        vecs.push_back(mk(1,1,0,16'h0020,16'h0,1,16'h0010, 0,16'hBEEF,0,16'hBEEF,1,0,16'h0020,16'h0));
        vecs.push_back(mk(1,1,0,16'h0020,16'h0,1,16'h0010, 0,16'hBEEF,0,16'hBEEF,1,0,16'h0020,16'h0));
        vecs.push_back(mk(1,1,0,16'h0020,16'h0,1,16'h0010, 1,16'h1234,0,16'hBEEF,0,0,16'h0020,16'h0));
        vecs.push_back(mk(1,0,0,16'h0020,16'h0,0,16'h0010, 0,16'h1234,0,16'hBEEF,0,0,16'h0020,16'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            reset = v.rst_n; cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr;
            cpu_wdata = v.cwdata; vid_req = v.vreq; vid_addr = v.vaddr;
            tick();
            n_vec++;
            if ({cpu_done, cpu_rdata, vid_done, vid_rdata, busy, mem_we, mem_addr, mem_wdata} !==
                {v.e_cdone, v.e_crdata, v.e_vdone, v.e_vrdata, v.e_busy, v.e_we, v.e_maddr,
                 v.e_mwdata}) begin
                n_err++;
                $display("FAIL vec%0d: got cdone=%b crd=%h vdone=%b vrd=%h busy=%b we=%b ma=%h mwd=%h expected cdone=%b crd=%h vdone=%b vrd=%h busy=%b we=%b ma=%h mwd=%h",
                         i, cpu_done, cpu_rdata, vid_done, vid_rdata, busy, mem_we, mem_addr,
                         mem_wdata, v.e_cdone, v.e_crdata, v.e_vdone, v.e_vrdata, v.e_busy,
                         v.e_we, v.e_maddr, v.e_mwdata);
            end
        end

        // Reset during CPU_ADDR of a write aborts the access without a done.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h5555;
        tick();
        check("abort_we_before", {15'h0, mem_we}, 16'h0001);
        reset = 1'b0;
        tick();
        check("abort_we_after", {15'h0, mem_we}, 16'h0000);
        check("abort_busy", {15'h0, busy}, 16'h0000);
        check("abort_done", {15'h0, cpu_done}, 16'h0000);
        check("abort_maddr", mem_addr, 16'h0000);
        check("abort_mwdata", mem_wdata, 16'h0000);
        reset = 1'b1; cpu_req = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            any_done = any_done | cpu_done;
        end
        check("abort_no_late_done", {15'h0, any_done}, 16'h0000);

        // Re-requested write completes in three cycles with a single write strobe.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h5555;
        wait_cpu_done(lat, we_cnt, seen);
        check("rewrite_done_seen", {15'h0, seen}, 16'h0001);
        check("rewrite_latency", lat[15:0], 16'd3);
        check("rewrite_we_cycles", we_cnt[15:0], 16'd1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();

        // Read back the re-written location.
        cpu_req = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h0000;
        wait_cpu_done(lat, we_cnt, seen);
        check("reread_done_seen", {15'h0, seen}, 16'h0001);
        check("reread_latency", lat[15:0], 16'd3);
        check("reread_we_cycles", we_cnt[15:0], 16'd0);
        check("reread_data", cpu_rdata, 16'h5555);
        cpu_req = 1'b0;
        tick();
        check("done_one_cycle", {15'h0, cpu_done}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
